// File: rtl/ref_window_feeder_pkg.sv
// ref_window_feeder_pkg: shared constants and playout state encoding for the reference window feeder
package ref_window_feeder_pkg;
  localparam int PIXEL_W = 8;
  localparam int ROW_PIX = 15;
  localparam int WIN_ROWS = 15;
  localparam int BEAT_PIX = 8;
  localparam int BEATS_PER_ROW = 2;
  localparam int BEATS_PER_WIN = BEATS_PER_ROW * WIN_ROWS;
  localparam int ROW_W = ROW_PIX * PIXEL_W;
  localparam int BEAT_W = BEAT_PIX * PIXEL_W;
  localparam int RIDX_W = $clog2(WIN_ROWS);
  localparam int BIDX_W = $clog2(BEATS_PER_WIN);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(WIN_ROWS - 1);
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS_PER_WIN - 1);
  typedef enum logic {IDLE, PLAY} play_state_t;
endpackage

// File: rtl/ref_window_feeder_if.sv
// ref_window_feeder_if: valid/ready pixel beat stream into the window feeder
// signals: valid, ready, data (pixel i at [8i+7:8i]), last (final beat of a window)
// modports: master drives beats, slave (the feeder) accepts them
interface ref_window_feeder_if;
  import ref_window_feeder_pkg::*;
  logic              valid;
  logic              ready;
  logic [BEAT_W-1:0] data;
  logic              last;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/ref_window_feeder_window_bank.sv
// window_bank: one 15x120 reference window buffer with a row-write port and a registered row-read port
// ports: clk; rst async active-low (clears only the read register); we/waddr/wdata row write;
//        re/raddr row read request; rdata registered row, holds while re is low
module window_bank import ref_window_feeder_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic              re,
  input  logic [RIDX_W-1:0] raddr,
  output logic [ROW_W-1:0]  rdata
);
  logic [ROW_W-1:0] mem [WIN_ROWS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ref_window_feeder.sv
// ref_window_feeder: assembles 64-bit pixel beats into 15x15 windows in ping-pong banks and plays them out row by row
// ports: clk; rst async active-low; s beat stream (slave); go downstream ready level;
//        out_row/out_valid/out_first/out_last row playout; busy playout active; err_last s_last framing pulse
module ref_window_feeder import ref_window_feeder_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  ref_window_feeder_if.slave  s,
  input  logic                go,
  output logic [ROW_W-1:0]    out_row,
  output logic                out_valid,
  output logic                out_first,
  output logic                out_last,
  output logic                busy,
  output logic                err_last
);
  play_state_t       state, nxt_state;
  logic [1:0]        full, full_n;
  logic              fill_ptr, rd_ptr, nxt_ptr, out_sel, beat_in_row;
  logic              accept, last_beat, free;
  logic [RIDX_W-1:0] row_idx, cur_row, nxt_row;
  logic [BEAT_W-1:0] hold;
  logic [ROW_W-1:0]  q [2];
  assign s.ready = !full[fill_ptr];
  assign accept = s.valid && s.ready;
  assign last_beat = {row_idx, beat_in_row} == LAST_BEAT;
  assign out_valid = state == PLAY;
  assign busy = out_valid;
  assign out_row = q[out_sel];
  // The bank being played is released on its last row; the other bank is judged on its
  // pre-edge full flag, so a window completing at that same edge waits one IDLE cycle.
  always_comb begin
    free = state == PLAY && cur_row == LAST_ROW;
    nxt_ptr = free ? !rd_ptr : rd_ptr;
    nxt_row = state == PLAY && !free ? cur_row + 1'b1 : '0;
    nxt_state = state == IDLE ? (full[rd_ptr] && go ? PLAY : IDLE)
              : free ? (full[!rd_ptr] && go ? PLAY : IDLE) : PLAY;
    full_n = full;
    if (free) full_n[rd_ptr] = 1'b0;
    if (accept && last_beat) full_n[fill_ptr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      full <= '0;
      fill_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      out_sel <= 1'b0;
      beat_in_row <= 1'b0;
      row_idx <= '0;
      cur_row <= '0;
      hold <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      err_last <= 1'b0;
    end else begin
      state <= nxt_state;
      rd_ptr <= nxt_ptr;
      cur_row <= nxt_row;
      full <= full_n;
      out_first <= nxt_state == PLAY && nxt_row == '0;
      out_last <= nxt_state == PLAY && nxt_row == LAST_ROW;
      if (nxt_state == PLAY) out_sel <= nxt_ptr;
      err_last <= accept && (s.last != last_beat);
      if (accept) begin
        if (!beat_in_row) hold <= s.data;
        beat_in_row <= !beat_in_row;
        if (beat_in_row) row_idx <= last_beat ? '0 : row_idx + 1'b1;
        if (last_beat) fill_ptr <= !fill_ptr;
      end
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    window_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && beat_in_row && fill_ptr == 1'(b)),
      .waddr (row_idx),
      .wdata ({s.data[ROW_W-BEAT_W-1:0], hold}),
      .re    (nxt_state == PLAY && nxt_ptr == 1'(b)),
      .raddr (nxt_row),
      .rdata (q[b])
    );
  end
endmodule

// File: tb/tb_ref_window_feeder.sv
// tb_ref_window_feeder: directed self-checking bench for ref_window_feeder
module tb_ref_window_feeder;
  import ref_window_feeder_pkg::*;
  logic clk = 0, rst = 0, go = 0;
  logic [ROW_W-1:0] out_row;
  logic out_valid, out_first, out_last, busy, err_last;
  int vec = 0, misc = 0, cyc = 0, errs = 0, last_acc = 0;
  logic [ROW_W+2:0] cap[$];
  int rcyc[$];
  ref_window_feeder_if s_if();
  ref_window_feeder dut (
    .clk(clk), .rst(rst), .s(s_if), .go(go), .out_row(out_row), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .busy(busy), .err_last(err_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (out_valid) begin
      cap.push_back({out_row, out_first, out_last, busy});
      rcyc.push_back(cyc);
    end
    if (err_last) errs++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end
  function automatic logic [ROW_W-1:0] exp_row(input int seed, input int r);
    logic [ROW_W-1:0] e;
    for (int c = 0; c < ROW_PIX; c++) e[8*c +: 8] = 8'(16 * r + c + seed);
    return e;
  endfunction
  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
    int n = 0;
    s_if.valid = 1; s_if.data = d; s_if.last = l;
    while (!s_if.ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!s_if.ready) begin
      $display("FAIL send_beat: s_ready=%b after %0d cycles, required 1", s_if.ready, n);
      misc++;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    s_if.valid = 0; s_if.last = 0;
  endtask
  task automatic send_window(input int seed, input int la, input int lb);
    logic [ROW_W-1:0] e;
    for (int b = 0; b < 30; b++) begin
      e = exp_row(seed, b / 2);
      send_beat(b % 2 ? {8'hFF, e[ROW_W-1:BEAT_W]} : e[BEAT_W-1:0], b == la || b == lb);
    end
  endtask
  task automatic wait_rows(input int n);
    int t = 0;
    while (cap.size() < n && t < 400) begin @(posedge clk); #1; t++; end
    vec++;
    if (cap.size() < n) begin
      $display("FAIL wait_rows: got %0d rows, required %0d", cap.size(), n);
      misc++;
    end
  endtask
  task automatic clear();
    cap.delete(); rcyc.delete(); errs = 0;
  endtask
  task automatic test_reset();
    s_if.valid = 0; s_if.data = '0; s_if.last = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({out_row, out_valid, out_first, out_last, busy, err_last, s_if.ready} !== {{ROW_W{1'b0}}, 6'b000001}) begin
      $display("FAIL reset_hold: outputs=%h, required %h", {out_row, out_valid, out_first, out_last, busy, err_last, s_if.ready}, {{ROW_W{1'b0}}, 6'b000001});
      misc++;
    end
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({out_valid, busy, err_last, s_if.ready} !== 4'b0001) begin
      $display("FAIL reset_release: valid/busy/err/ready=%b, required 0001", {out_valid, busy, err_last, s_if.ready});
      misc++;
    end
  endtask
  task automatic test_single();
    int k;
    clear();
    go = 1;
    send_window(0, 29, 29);
    k = last_acc;
    wait_rows(15);
    repeat (5) @(posedge clk);
    #1;
    for (int r = 0; r < 15; r++) begin
      vec++;
      if (cap[r] !== {exp_row(0, r), r == 0, r == 14, 1'b1}) begin
        $display("FAIL single_row%0d: got %h, required %h", r, cap[r], {exp_row(0, r), r == 0, r == 14, 1'b1});
        misc++;
      end
    end
    vec++;
    if (rcyc[0] !== k + 1 || rcyc[14] !== k + 15) begin
      $display("FAIL single_latency: rows at cycles %0d..%0d, required %0d..%0d", rcyc[0], rcyc[14], k + 1, k + 15);
      misc++;
    end
    vec++;
    if (cap.size() !== 15 || errs !== 0) begin
      $display("FAIL single_count: rows=%0d errs=%0d, required 15 and 0", cap.size(), errs);
      misc++;
    end
  endtask
  task automatic test_back_to_back();
    int g, t = 0;
    clear();
    go = 0;
    send_window(1, 29, 29);
    send_window(2, 29, 29);
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (s_if.ready !== 1'b0 || cap.size() !== 0) begin
      $display("FAIL b2b_stall: ready=%b rows=%0d, required 0 and 0", s_if.ready, cap.size());
      misc++;
    end
    go = 1;
    g = cyc;
    while (!(out_valid && out_last) && t < 100) begin @(negedge clk); t++; end
    vec++;
    if (s_if.ready !== 1'b0) begin
      $display("FAIL b2b_ready_at_last: ready=%b, required 0", s_if.ready);
      misc++;
    end
    @(posedge clk); #1;
    vec++;
    if (s_if.ready !== 1'b1) begin
      $display("FAIL b2b_ready_after_last: ready=%b, required 1", s_if.ready);
      misc++;
    end
    wait_rows(30);
    for (int i = 0; i < 30; i++) begin
      vec++;
      if (cap[i] !== {exp_row(i < 15 ? 1 : 2, i % 15), i % 15 == 0, i % 15 == 14, 1'b1} || rcyc[i] !== g + 1 + i) begin
        $display("FAIL b2b_row%0d: got %h at cycle %0d, required %h at cycle %0d", i, cap[i], rcyc[i], {exp_row(i < 15 ? 1 : 2, i % 15), i % 15 == 0, i % 15 == 14, 1'b1}, g + 1 + i);
        misc++;
      end
    end
  endtask
  task automatic test_framing();
    clear();
    go = 1;
    send_window(3, 10, -1);
    wait_rows(15);
    for (int r = 0; r < 15; r++) begin
      vec++;
      if (cap[r] !== {exp_row(3, r), r == 0, r == 14, 1'b1}) begin
        $display("FAIL framing_row%0d: got %h, required %h", r, cap[r], {exp_row(3, r), r == 0, r == 14, 1'b1});
        misc++;
      end
    end
    vec++;
    if (errs !== 2) begin
      $display("FAIL framing_err_pulses: got %0d, required 2", errs);
      misc++;
    end
  endtask
  task automatic test_concurrent();
    clear();
    go = 1;
    send_window(4, 29, 29);
    send_window(5, 29, 29);
    wait_rows(30);
    for (int i = 0; i < 30; i++) begin
      vec++;
      if (cap[i] !== {exp_row(i < 15 ? 4 : 5, i % 15), i % 15 == 0, i % 15 == 14, 1'b1}) begin
        $display("FAIL concurrent_row%0d: got %h, required %h", i, cap[i], {exp_row(i < 15 ? 4 : 5, i % 15), i % 15 == 0, i % 15 == 14, 1'b1});
        misc++;
      end
    end
    vec++;
    if (errs !== 0) begin
      $display("FAIL concurrent_err: got %0d pulses, required 0", errs);
      misc++;
    end
  endtask
  task automatic test_reset_mid();
    clear();
    go = 1;
    send_window(6, 29, 29);
    wait_rows(8);
    #2 rst = 0;
    #1;
    vec++;
    if ({out_row, out_valid, out_first, out_last, busy} !== {{ROW_W{1'b0}}, 4'b0}) begin
      $display("FAIL reset_play: outputs=%h, required 0", {out_row, out_valid, out_first, out_last, busy});
      misc++;
    end
    @(posedge clk); #1;
    rst = 1;
    for (int b = 0; b < 15; b++) begin
      logic [ROW_W-1:0] e;
      e = exp_row(7, b / 2);
      send_beat(b % 2 ? {8'hFF, e[ROW_W-1:BEAT_W]} : e[BEAT_W-1:0], 1'b0);
    end
    #2 rst = 0;
    #1;
    vec++;
    if ({out_valid, busy, err_last, s_if.ready} !== 4'b0001) begin
      $display("FAIL reset_fill: valid/busy/err/ready=%b, required 0001", {out_valid, busy, err_last, s_if.ready});
      misc++;
    end
    @(posedge clk); #1;
    rst = 1;
    clear();
    repeat (20) @(posedge clk);
    #1;
    vec++;
    if (cap.size() !== 0) begin
      $display("FAIL reset_no_rows: got %0d rows, required 0", cap.size());
      misc++;
    end
    send_window(8, 29, 29);
    wait_rows(15);
    for (int r = 0; r < 15; r++) begin
      vec++;
      if (cap[r] !== {exp_row(8, r), r == 0, r == 14, 1'b1}) begin
        $display("FAIL reset_recover_row%0d: got %h, required %h", r, cap[r], {exp_row(8, r), r == 0, r == 14, 1'b1});
        misc++;
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_concurrent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end
endmodule

// File: doc/ref_window_feeder.md
# ref_window_feeder

Upstream feeder for the sub-pixel interpolation datapath. Accepts reference pixels as 64-bit beats over a valid/ready stream, assembles them into 15-pixel rows, and buffers a complete 15x15 reference window (8x8 block plus 7-pixel filter margin) in one of two ping-pong banks. On request it plays a full window out as 15 consecutive 120-bit rows, the format the interpolator's `in_row` input consumes, while the other bank fills.

## Interface
- `PIXEL_W`, 8, bits per pixel
- `ROW_PIX`, 15, pixels per window row
- `WIN_ROWS`, 15, rows per window
- `BEAT_PIX`, 8, pixels per input beat

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `s_valid` input 1: input beat valid.
- `s_ready` output 1: feeder accepts a beat this cycle.
- `s_data` input 64: pixel i at bits `[8i+7:8i]`.
- `s_last` input 1: marks the final beat of a window.
- `go` input 1: level; downstream ready to receive a window.
- `out_row` output 120: row pixels, pixel j at `[8j+7:8j]`.
- `out_valid` output 1: `out_row` holds a window row.
- `out_first` output 1: row 0 of a window.
- `out_last` output 1: row 14 of a window.
- `busy` output 1: playout in progress.
- `err_last` output 1: one-cycle pulse on an `s_last` framing error.

## Operation
- Beat accepted when `s_valid && s_ready`.
- Each row takes 2 beats:
  - beat 0 supplies pixels 0..7;
  - beat 1 supplies pixels 8..14 from bits `[55:0]`; bits `[63:56]` are ignored.
- A window is 30 beats. Fill counters: `beat_in_row` (0..1) and `row_idx` (0..14).
- On the 30th beat the fill bank is marked full, the fill pointer toggles to the other bank, and the counters wrap to 0.
- `s_last` check:
  - `s_last` is required on beat 29 only.
  - `s_last` high on any other beat, or low on beat 29, pulses `err_last` for one cycle.
  - The window still closes strictly on the beat count; `s_last` never truncates or extends it.
- `s_ready` = fill bank not full (combinational from the bank-full flags).
- Playout FSM:
  - IDLE: if a full bank exists and `go` is high, go to PLAY with read row 0. Banks play oldest-first (strict alternation).
  - PLAY: emit one row per cycle (`out_valid`=1, `busy`=1). `go` is ignored mid-window.
  - On row 14 (`out_last`=1): the bank is freed at that edge.
    - If the other bank is full and `go` is high, the next cycle is row 0 of the other bank (back-to-back, no bubble).
    - Otherwise return to IDLE.
- Simultaneous events:
  - A bank freeing at the same edge as the other bank completing is legal. The freed bank may accept a beat on the next cycle.
  - Filling and playing different banks in the same cycle is always legal.
- Outside PLAY, `out_row` holds its last value; `out_valid`, `out_first` and `out_last` are 0.

## Timing
- Reset values:
  - 0: `out_row`, `out_valid`, `out_first`, `out_last`, `busy`, `err_last`, both bank-full flags, all counters.
  - FSM = IDLE, fill and read pointers = bank 0.
  - `s_ready` = 1.
- Reset asserted mid-operation discards partial rows and both banks. Outputs return to reset values asynchronously. No row is emitted after reset release until a new 30-beat window completes.
- All stream outputs are registered.
- Latency, cycle = one clock edge:
  - Final beat accepted at edge k, FSM in IDLE, `go` high: first `out_valid` at edge k+1.
  - `go` rising while a full bank waits: row 0 valid the edge after `go` is sampled.
- A window occupies exactly 15 consecutive `out_valid` cycles.
- `err_last` is registered and asserts the edge after the offending beat.
- Throughput: one window per 30 input cycles sustained. The input stalls only when both banks are full.

## Structure
- Shared package holds:
  - constants `PIXEL_W`, `ROW_PIX`, `WIN_ROWS`, `BEATS_PER_ROW`=2, `BEATS_PER_WIN`=30;
  - `ROW_W`=`ROW_PIX*PIXEL_W`;
  - playout FSM state encoding.
- One sub-module, `window_bank`:
  - 15x120 storage with a row-write port (write-enable, row index, 120-bit data) and a registered row-read port;
  - instantiated twice.
- Top level holds the beat assembler (64-bit holding register for beat 0), fill/read pointers, full flags, FSM and `err_last` logic.

## Test plan
- Single window with `go` held high: 30 beats, pixel value = 16*row + col → 15 rows. Row r pixel c = 16r+c. `out_first` on row 0, `out_last` on row 14, first `out_valid` one cycle after the last beat.
- Back-pressure: 60 beats with `go` low → `s_ready` drops after beat 59. Raise `go` → 30 back-to-back rows (bank 0 then bank 1), no bubble. `s_ready` rises after the first `out_last`.
- Bits `[63:56]` of odd beats = 0xFF → never appear in `out_row[119:112]` or anywhere else.
- Framing: `s_last` on beat 10 and missing on beat 29 → two `err_last` pulses. The window still emits after beat 29 with correct data.
- Concurrent fill/play: stream window 2 while window 1 plays → window 2 data intact and played in order.
- Reset at row 7 of playout and again at mid-fill → outputs 0 immediately. A new full window after release plays correctly from row 0.
